// File: rtl/alarm_annunciator_if.sv
// Alarm annunciator pin bundle: alarm/button pulses in, tone drive and ring status out.
// Master drives the pulses; slave is the annunciator itself.
interface alarm_annunciator_if;
  logic       alarm_trigger;
  logic       btn_snooze;
  logic       btn_dismiss;
  logic       speaker_out;
  logic       ringing;
  logic       snoozed;
  logic [3:0] snooze_count;

  modport master (
    output alarm_trigger, btn_snooze, btn_dismiss,
    input  speaker_out, ringing, snoozed, snooze_count
  );

  modport slave (
    input  alarm_trigger, btn_snooze, btn_dismiss,
    output speaker_out, ringing, snoozed, snooze_count
  );
endinterface

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: ring cadence with square-wave tone, dismiss and auto-silence; inputs act on the next edge, no backpressure.
// ALARM_SNOOZE_EN adds the SNOOZE state; without it btn_snooze is ignored and snoozed/snooze_count read 0.
module alarm_annunciator #(
  parameter int TONE_DIV       = 25000,
  parameter int CADENCE_CYC    = 25000000,
  parameter int RING_PERIODS   = 60,
  parameter int SNOOZE_PERIODS = 600,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  alarm_annunciator_if.slave bus
);
  localparam int PH_W = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;
  localparam int TD_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int RP_W = (RING_PERIODS > 1) ? $clog2(RING_PERIODS) : 1;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {SILENT, RING_ON, RING_OFF, SNOOZE} state_t;
`else
  typedef enum logic [1:0] {SILENT, RING_ON, RING_OFF} state_t;
`endif

  state_t          state, state_nx;
  logic [PH_W-1:0] ph;
  logic [TD_W-1:0] tdiv;
  logic [RP_W-1:0] rp;
  logic            speaker;
  logic            ph_end, tone_end, rp_last, ring_act, stay_on;

  assign ph_end   = (ph == PH_W'(CADENCE_CYC - 1));
  assign tone_end = (tdiv == TD_W'(TONE_DIV - 1));
  assign rp_last  = (rp == RP_W'(RING_PERIODS - 1));
  assign ring_act = (state == RING_ON) || (state == RING_OFF);
  assign stay_on  = (state == RING_ON) && (state_nx == RING_ON);

`ifdef ALARM_SNOOZE_EN
  localparam int SP_W = (SNOOZE_PERIODS > 1) ? $clog2(SNOOZE_PERIODS) : 1;
  logic [SP_W-1:0] sp;
  logic [3:0]      scnt;
  logic            snooze_go, sp_last;

  assign snooze_go = ring_act && bus.btn_snooze && (scnt < 4'(MAX_SNOOZE));
  assign sp_last   = (sp == SP_W'(SNOOZE_PERIODS - 1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SILENT;
    else          state <= state_nx;
  end

  // Buttons are evaluated before phase expiry so a press on the last cycle still wins.
  always_comb begin
    state_nx = state;
    case (state)
      SILENT: begin
        if (bus.alarm_trigger) state_nx = RING_ON;
      end
      RING_ON, RING_OFF: begin
        if (bus.btn_dismiss)   state_nx = SILENT;
`ifdef ALARM_SNOOZE_EN
        else if (snooze_go)    state_nx = SNOOZE;
`endif
        else if (ph_end) begin
          if (state == RING_ON) state_nx = RING_OFF;
          else if (rp_last)     state_nx = SILENT;
          else                  state_nx = RING_ON;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (bus.btn_dismiss)        state_nx = SILENT;
        else if (ph_end && sp_last) state_nx = RING_ON;
      end
`endif
      default: state_nx = SILENT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph      <= '0;
      tdiv    <= '0;
      rp      <= '0;
      speaker <= 1'b0;
    end else begin
      // In SNOOZE the phase counter wraps each cadence unit; sp counts the units.
      if ((state == SILENT) || (state_nx != state) || ph_end) ph <= '0;
      else                                                     ph <= ph + 1'b1;

      if (stay_on) begin
        tdiv <= tone_end ? '0 : tdiv + 1'b1;
        if (tone_end) speaker <= ~speaker;
      end else begin
        tdiv    <= '0;
        speaker <= 1'b0;
      end

      if (!ring_act)                                   rp <= '0;
      else if (state == RING_OFF && state_nx == RING_ON) rp <= rp + 1'b1;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp   <= '0;
      scnt <= 4'd0;
    end else begin
      if ((state == SNOOZE) && (state_nx == SNOOZE)) begin
        if (ph_end) sp <= sp + 1'b1;
      end else begin
        sp <= '0;
      end

      // snooze_count survives a dismiss and is only cleared by the next alarm event.
      if ((state == SILENT) && bus.alarm_trigger)           scnt <= 4'd0;
      else if ((state_nx == SNOOZE) && (state != SNOOZE))   scnt <= scnt + 4'd1;
    end
  end

  assign bus.snoozed      = (state == SNOOZE);
  assign bus.snooze_count = scnt;
`else
  logic unused_snooze_btn;
  assign unused_snooze_btn = bus.btn_snooze;
  assign bus.snoozed       = 1'b0;
  assign bus.snooze_count  = 4'd0;
`endif

  assign bus.speaker_out = speaker;
  assign bus.ringing     = ring_act;
endmodule

// File: tb/tb_alarm_annunciator.sv
// Self-checking bench for alarm_annunciator using a time-based reference model of the ring/snooze event.
module tb_alarm_annunciator;
  localparam int TD = 2, C = 8, RP = 3, SP = 4, MAXS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  alarm_annunciator_if bus();

  alarm_annunciator #(
    .TONE_DIV(TD), .CADENCE_CYC(C), .RING_PERIODS(RP),
    .SNOOZE_PERIODS(SP), .MAX_SNOOZE(MAXS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 silent, 1 ringing, 2 snoozed; m_t = cycles since ringing (re)started.
  int m_mode, m_t, m_s, m_cnt;

  function automatic void m_reset();
    m_mode = 0; m_t = 0; m_s = 0; m_cnt = 0;
  endfunction

  function automatic void m_step(input bit t, input bit s, input bit d);
    case (m_mode)
      0: if (t) begin m_mode = 1; m_t = 0; m_cnt = 0; end
      1: begin
        if (d) m_mode = 0;
        else if (s && SNZ && m_cnt < MAXS) begin m_mode = 2; m_s = 0; m_cnt++; end
        else begin
          m_t++;
          if (m_t == RP * 2 * C) m_mode = 0;
        end
      end
      default: begin
        if (d) m_mode = 0;
        else begin
          m_s++;
          if (m_s == SP * C) begin m_mode = 1; m_t = 0; end
        end
      end
    endcase
  endfunction

  function automatic logic [6:0] m_out();
    int  pos;
    logic spk;
    pos = m_t % (2 * C);
    spk = (m_mode == 1) && (pos < C) && (((pos / TD) % 2) == 1);
    return {spk, (m_mode == 1), (m_mode == 2), 4'(m_cnt)};
  endfunction

  function automatic logic [6:0] dut_out();
    return {bus.speaker_out, bus.ringing, bus.snoozed, bus.snooze_count};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, return at edge+1.
  task automatic tick(input bit t, input bit s, input bit d);
    bus.alarm_trigger = t; bus.btn_snooze = s; bus.btn_dismiss = d;
    @(posedge clk);
    m_step(t, s, d);
    #1;
    bus.alarm_trigger = 1'b0; bus.btn_snooze = 1'b0; bus.btn_dismiss = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_out() !== 7'd0) begin n_bad++; $display("FAIL reset_state: got %b expected %b", dut_out(), 7'd0); end
    reset_n = 1'b1;
    repeat (3) begin
      tick(0, 1, 1);
      n_cmp++;
      if (dut_out() !== 7'd0) begin n_bad++; $display("FAIL silent_buttons: got %b expected %b", dut_out(), 7'd0); end
    end
    tick(1, 1, 1);
    n_cmp++;
    if (dut_out() !== 7'b0100000) begin n_bad++; $display("FAIL trigger_with_buttons: got %b expected %b", dut_out(), 7'b0100000); end
    tick(0, 0, 1);
    n_cmp++;
    if (dut_out() !== m_out()) begin n_bad++; $display("FAIL reset_dismiss: got %b expected %b", dut_out(), m_out()); end
  endtask

  task automatic test_tone();
    bit pat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_spk;
    tick(1, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick(0, 0, 0);
      exp_spk = (c <= 8) ? pat[c-1] : 1'b0;
      n_cmp++;
      if (bus.speaker_out !== exp_spk || bus.ringing !== 1'b1) begin
        n_bad++;
        $display("FAIL tone_cycle%0d: got spk=%b ring=%b expected spk=%b ring=1", c, bus.speaker_out, bus.ringing, exp_spk);
      end
    end
    tick(0, 0, 1);
    n_cmp++;
    if (bus.ringing !== 1'b0 || bus.speaker_out !== 1'b0) begin
      n_bad++; $display("FAIL tone_dismiss: got ring=%b spk=%b expected 0 0", bus.ringing, bus.speaker_out);
    end
  endtask

  task automatic test_auto_silence();
    int cyc;
    tick(1, 0, 0);
    cyc = 1;
    while (bus.ringing === 1'b1 && cyc < 200) begin
      tick(0, 0, 0);
      cyc++;
      n_cmp++;
      if (dut_out() !== m_out()) begin n_bad++; $display("FAIL auto_model c%0d: got %b expected %b", cyc, dut_out(), m_out()); end
    end
    n_cmp++;
    if (cyc != 49 || bus.speaker_out !== 1'b0) begin
      n_bad++; $display("FAIL auto_silence: got silent at cycle %0d spk=%b expected cycle 49 spk=0", cyc, bus.speaker_out);
    end
  endtask

  task automatic test_snooze();
    int ring_len;
    tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);
    tick(0, 1, 0);
    n_cmp++;
    if (bus.snoozed !== SNZ || bus.snooze_count !== 4'(SNZ ? 1 : 0)) begin
      n_bad++; $display("FAIL snooze_enter: got snoozed=%b count=%0d expected %b %0d", bus.snoozed, bus.snooze_count, SNZ, SNZ ? 1 : 0);
    end
`ifdef ALARM_SNOOZE_EN
    for (int i = 0; i < 31; i++) begin
      tick(0, 0, 0);
      n_cmp++;
      if (bus.speaker_out !== 1'b0 || bus.snoozed !== 1'b1) begin
        n_bad++; $display("FAIL snooze_quiet i%0d: got spk=%b snoozed=%b expected 0 1", i, bus.speaker_out, bus.snoozed);
      end
    end
    ring_len = 0;
    tick(0, 0, 0);
    while (bus.ringing === 1'b1 && ring_len < 200) begin
      ring_len++;
      n_cmp++;
      if (dut_out() !== m_out()) begin n_bad++; $display("FAIL snooze_resume_model r%0d: got %b expected %b", ring_len, dut_out(), m_out()); end
      tick(0, 0, 0);
    end
    n_cmp++;
    if (ring_len != 48 || bus.snooze_count !== 4'd1) begin
      n_bad++; $display("FAIL snooze_budget: got %0d ring cycles count=%0d expected 48 count=1", ring_len, bus.snooze_count);
    end
`else
    ring_len = 0;
    while (bus.ringing === 1'b1 && ring_len < 200) begin
      ring_len++;
      n_cmp++;
      if (dut_out() !== m_out()) begin n_bad++; $display("FAIL snooze_ignored_model r%0d: got %b expected %b", ring_len, dut_out(), m_out()); end
      tick(0, 0, 0);
    end
`endif
    tick(0, 0, 1);
  endtask

  task automatic test_snooze_limit();
    tick(1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      tick(0, 1, 0);
      for (int i = 0; i < 32; i++) begin
        tick(0, 0, 0);
        n_cmp++;
        if (dut_out() !== m_out()) begin n_bad++; $display("FAIL limit_model k%0d i%0d: got %b expected %b", k, i, dut_out(), m_out()); end
      end
    end
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    n_cmp++;
    if (bus.snooze_count !== 4'(SNZ ? 2 : 0) || bus.snoozed !== 1'b0) begin
      n_bad++; $display("FAIL third_snooze: got count=%0d snoozed=%b expected %0d 0", bus.snooze_count, bus.snoozed, SNZ ? 2 : 0);
    end
`ifdef ALARM_SNOOZE_EN
    n_cmp++;
    if (bus.ringing !== 1'b1 || bus.speaker_out !== 1'b1) begin
      n_bad++; $display("FAIL third_snooze_tone: got ring=%b spk=%b expected 1 1", bus.ringing, bus.speaker_out);
    end
`endif
    repeat (3) begin
      tick(0, 0, 0);
      n_cmp++;
      if (dut_out() !== m_out()) begin n_bad++; $display("FAIL limit_continue: got %b expected %b", dut_out(), m_out()); end
    end
    tick(0, 0, 1);
    n_cmp++;
    if (dut_out() !== {3'b000, 4'(SNZ ? 2 : 0)}) begin
      n_bad++; $display("FAIL limit_dismiss: got %b expected %b", dut_out(), {3'b000, 4'(SNZ ? 2 : 0)});
    end
  endtask

  task automatic test_dismiss_priority();
    int ring_len;
    tick(1, 0, 0);
    tick(0, 1, 0);
    repeat (33) tick(0, 0, 0);
    tick(0, 1, 1);
    n_cmp++;
    if (dut_out() !== {3'b000, 4'(SNZ ? 1 : 0)}) begin
      n_bad++; $display("FAIL snooze_plus_dismiss: got %b expected %b", dut_out(), {3'b000, 4'(SNZ ? 1 : 0)});
    end
    tick(1, 0, 0);
    ring_len = 1;
    while (bus.ringing === 1'b1 && ring_len < 200) begin
      tick((ring_len % 7) == 3, 1'b0, 1'b0);
      ring_len++;
      n_cmp++;
      if (dut_out() !== m_out()) begin n_bad++; $display("FAIL retrigger_model r%0d: got %b expected %b", ring_len, dut_out(), m_out()); end
    end
    n_cmp++;
    if (ring_len != 49) begin n_bad++; $display("FAIL retrigger_no_restart: got silent at %0d expected 49", ring_len); end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    n_cmp++;
    if (bus.speaker_out !== 1'b1 || bus.ringing !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_tone: got spk=%b ring=%b expected 1 1", bus.speaker_out, bus.ringing);
    end
    #3 reset_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (dut_out() !== 7'd0) begin n_bad++; $display("FAIL async_reset: got %b expected %b", dut_out(), 7'd0); end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(0, i[0], 1'b0);
      n_cmp++;
      if (dut_out() !== 7'd0) begin n_bad++; $display("FAIL post_reset_silent i%0d: got %b expected %b", i, dut_out(), 7'd0); end
    end
    tick(1, 0, 0);
    n_cmp++;
    if (dut_out() !== 7'b0100000) begin n_bad++; $display("FAIL post_reset_trigger: got %b expected %b", dut_out(), 7'b0100000); end
    tick(0, 0, 1);
  endtask

  task automatic test_random();
    bit t, s, d;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 19) == 0);
      d = ($urandom_range(0, 79) == 0);
      tick(t, s, d);
      n_cmp++;
      if (dut_out() !== m_out()) begin n_bad++; $display("FAIL random i%0d: got %b expected %b", i, dut_out(), m_out()); end
    end
  endtask

  initial begin
    bus.alarm_trigger = 1'b0;
    bus.btn_snooze    = 1'b0;
    bus.btn_dismiss   = 1'b0;
    m_reset();
    test_reset();
    test_tone();
    test_auto_silence();
    test_snooze();
    test_snooze_limit();
    test_dismiss_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
